noc_rr_sched: RTL and testbench

Round-robin scheduler for a NoC tree merge node. It shares one output link among `N_REQ` upstream show-ahead FIFOs. It grants one FIFO at a time for bursts of up to `MAX_BURST` words, pops the granted FIFO, and drives a registered output word whose MSB is the validity bit. It sits between the per-input `buffer` instances of a merge node and the next tree level, and replaces the fixed two-way left/right alternation with an N-way, burst-bounded, busy-aware policy.

---
 rtl/noc_pkg.sv | 26 ++
 rtl/noc_rr_pick.sv | 40 ++++
 rtl/noc_rr_sched.sv | 139 +++++++++++++
 tb/tb_noc_rr_sched.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the NoC merge-node scheduler.
//   clog2          : ceiling log2, used to size index and counter fields
//   DEF_VAL_BIT    : default number of validity bits at the MSB of a word
//   DEF_WORD_WIDTH : default output word width (validity bits included)
//   state_t        : scheduler state encoding (S_IDLE, S_GRANT)
// -----------------------------------------------------------------------------
package noc_pkg;

  localparam int DEF_VAL_BIT    = 1;
  localparam int DEF_WORD_WIDTH = 16;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// -----------------------------------------------------------------------------
// noc_rr_pick
// Combinational rotate-priority picker. Scans req starting at index 'start'
// and wrapping modulo N_REQ; the first set bit wins.
//   req    : request vector
//   start  : index with highest priority (must be < N_REQ)
//   winner : index of the first set request in rotated order
//   any    : at least one request is set (winner is 0 when clear)
// -----------------------------------------------------------------------------
module noc_rr_pick
  import noc_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    start,
  output logic [IW-1:0]    winner,
  output logic             any
);

  int idx;

  // Walk the rotated order once; 'any' latches the first hit so later
  // candidates cannot overwrite the winner.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(start) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any && req[idx[IW-1:0]]) begin
        any    = 1'b1;
        winner = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/noc_rr_sched.sv
// -----------------------------------------------------------------------------
// noc_rr_sched
// Round-robin, burst-bounded, busy-aware scheduler sharing one output link
// among N_REQ show-ahead FIFOs of a NoC tree merge node.
//   clk     : clock, all state on the rising edge
//   rst     : asynchronous active-low reset
//   busy    : downstream stall, blocks pops (not arbitration)
//   req     : per-FIFO non-empty flags
//   data_in : FIFO head words, slice i at [i*DW +: DW]
//   rd      : one-hot pop strobe, combinational
//   grant   : one-hot current owner, zero when idle
//   out     : registered word, validity bits at the MSB
// -----------------------------------------------------------------------------
module noc_rr_sched
  import noc_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int word_width = DEF_WORD_WIDTH,
  parameter int val_bit    = DEF_VAL_BIT,
  parameter int MAX_BURST  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 busy,
  input  logic [N_REQ-1:0]                     req,
  input  logic [N_REQ*(word_width-val_bit)-1:0] data_in,
  output logic [N_REQ-1:0]                     rd,
  output logic [N_REQ-1:0]                     grant,
  output logic [word_width-1:0]                out
);

  localparam int DW = word_width - val_bit;
  localparam int IW = (clog2(N_REQ) < 1) ? 1 : clog2(N_REQ);
  // One spare count value keeps the field at least one bit wide even when
  // MAX_BURST is 1.
  localparam int CW = clog2(MAX_BURST + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(MAX_BURST - 1);

  state_t            state, state_n;
  logic [IW-1:0]     sel, sel_n;
  logic [IW-1:0]     last, last_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [IW-1:0]     pick_start;
  logic [IW-1:0]     pick_win;
  logic              pick_any;
  logic              pop;
  logic              grant_end;
  logic [word_width-1:0] out_n;
  logic [DW-1:0]     heads [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_heads
    assign heads[i] = data_in[i*DW +: DW];
  end

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + IW'(1);
  endfunction

  // A single picker serves both cases: from IDLE the search resumes after the
  // last owner, at the end of a grant it starts after the current owner, so
  // the current owner naturally ranks last.
  assign pick_start = (state == S_IDLE) ? next_idx(last) : next_idx(sel);

  noc_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req    (req),
    .start  (pick_start),
    .winner (pick_win),
    .any    (pick_any)
  );

  // Next-state, pop strobe and output word. Without a pop the validity bits
  // drop while the data bits keep their last value.
  always_comb begin
    state_n   = state;
    sel_n     = sel;
    last_n    = last;
    cnt_n     = cnt;
    pop       = 1'b0;
    grant_end = 1'b0;
    rd        = '0;
    grant     = '0;
    out_n     = {{val_bit{1'b0}}, out[DW-1:0]};
    case (state)
      S_IDLE: begin
        if (pick_any) begin
          state_n = S_GRANT;
          sel_n   = pick_win;
          last_n  = pick_win;
          cnt_n   = '0;
        end
      end
      S_GRANT: begin
        grant[sel] = 1'b1;
        pop        = req[sel] && !busy;
        if (pop) begin
          rd[sel] = 1'b1;
          out_n   = {{val_bit{1'b1}}, heads[sel]};
          cnt_n   = cnt + CW'(1);
        end
        // A drained owner ends the grant even under busy; a stalled owner
        // with data keeps it.
        grant_end = (pop && (cnt == CNT_END)) || !req[sel];
        if (grant_end) begin
          cnt_n = '0;
          if (pick_any) begin
            sel_n  = pick_win;
            last_n = pick_win;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State registers; reset points 'last' at the top index so the first
  // search starts at index 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      sel   <= '0;
      last  <= LAST_IDX;
      cnt   <= '0;
      out   <= '0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      last  <= last_n;
      cnt   <= cnt_n;
      out   <= out_n;
    end
  end

endmodule

// File: tb/tb_noc_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_noc_rr_sched
// Self-checking bench for noc_rr_sched (N_REQ=4, word_width=16, val_bit=1,
// MAX_BURST=4). Four show-ahead FIFOs are modelled as arrays with pointers and
// are popped whenever the scheduler strobes rd. A reference model tracks the
// owner, the round-robin pointer and the pops in the current burst, and its
// predictions are compared against rd, grant and out every cycle. Directed
// scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_noc_rr_sched;

  localparam int N  = 4;
  localparam int MB = 4;
  localparam int DW = 15;

  logic            clk;
  logic            rst;
  logic            busy;
  logic [N-1:0]    req;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]    rd;
  logic [N-1:0]    grant;
  logic [15:0]     out;

  noc_rr_sched #(
    .N_REQ      (N),
    .word_width (16),
    .val_bit    (1),
    .MAX_BURST  (MB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .busy    (busy),
    .req     (req),
    .data_in (data_in),
    .rd      (rd),
    .grant   (grant),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // FIFO storage
  logic [DW-1:0] mem [N][16];
  int headPtr [N];
  int tailPtr [N];
  logic [N-1:0] sampledRd;
  logic skipPop;

  // Reference model state
  int owner;
  int mLast;
  int mPops;
  logic [15:0] mOut;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int search(input int from, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (from + k) % N;
      if (r[i[1:0]]) return i;
    end
    return -1;
  endfunction

  task automatic modelReset();
    owner = -1;
    mLast = N - 1;
    mPops = 0;
    mOut  = '0;
  endtask

  task automatic modelSeq();
    int  w;
    logic popped;
    if (!rst) begin
      modelReset();
      return;
    end
    popped = (owner >= 0) && req[owner[1:0]] && !busy;
    if (popped) mOut = {1'b1, data_in[owner*DW +: DW]};
    else        mOut[15] = 1'b0;
    if (owner < 0) begin
      w = search((mLast + 1) % N, req);
      if (w >= 0) begin
        owner = w;
        mLast = w;
        mPops = 0;
      end
    end else begin
      if (popped) mPops++;
      if ((popped && mPops == MB) || !req[owner[1:0]]) begin
        w = search((owner + 1) % N, req);
        if (w >= 0) begin
          owner = w;
          mLast = w;
          mPops = 0;
        end else begin
          owner = -1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic b);
    busy = b;
    for (int i = 0; i < N; i++) begin
      req[i] = (headPtr[i] != tailPtr[i]);
      data_in[i*DW +: DW] = req[i] ? mem[i][headPtr[i]] : '0;
    end
  endtask

  task automatic pushWord(input int i, input logic [DW-1:0] w);
    mem[i][tailPtr[i]] = w;
    tailPtr[i]++;
  endtask

  task automatic checkCycle();
    logic [N-1:0] expRd;
    logic [N-1:0] expGrant;
    expRd    = '0;
    expGrant = '0;
    if (owner >= 0) begin
      expGrant[owner[1:0]] = 1'b1;
      if (req[owner[1:0]] && !busy) expRd[owner[1:0]] = 1'b1;
    end
    checkOutput("model_rd",    {12'b0, rd},    {12'b0, expRd});
    checkOutput("model_grant", {12'b0, grant}, {12'b0, expGrant});
    checkOutput("model_out",   out,            mOut);
    sampledRd = rd;
  endtask

  // One clock cycle: model and FIFOs advance with the edge, new inputs are
  // driven shortly after it, outputs are compared on the falling edge.
  task automatic tick(input logic b);
    @(posedge clk);
    #2;
    modelSeq();
    if (!skipPop) begin
      for (int i = 0; i < N; i++)
        if (sampledRd[i] && headPtr[i] != tailPtr[i]) headPtr[i]++;
    end
    skipPop = 1'b0;
    applyStimulus(b);
    @(negedge clk);
    checkCycle();
  endtask

  task automatic assertReset(input logic clearFifos);
    rst       = 1'b0;
    skipPop   = 1'b1;
    sampledRd = '0;
    modelReset();
    if (clearFifos) begin
      for (int i = 0; i < N; i++) begin
        headPtr[i] = 0;
        tailPtr[i] = 0;
      end
    end
    applyStimulus(1'b0);
  endtask

  task automatic releaseReset();
    rst = 1'b1;
    applyStimulus(1'b0);
  endtask

  initial begin
    logic [N-1:0] order [5];
    req     = '0;
    data_in = '0;
    busy    = 1'b0;
    assertReset(1'b1);
    tick(1'b0);
    tick(1'b0);
    checkOutput("reset_rd",    {12'b0, rd},    16'h0000);
    checkOutput("reset_grant", {12'b0, grant}, 16'h0000);
    checkOutput("reset_out",   out,            16'h0000);

    // Single requester: burst of 4, re-granted with no bubble
    for (int k = 1; k <= 6; k++) pushWord(0, 15'(16'h00A0 + k));
    releaseReset();
    for (int k = 1; k <= 6; k++) begin
      tick(1'b0);
      checkOutput("single_grant", {12'b0, grant}, 16'h0001);
      checkOutput("single_rd",    {12'b0, rd},    16'h0001);
      checkOutput("single_out",   out, (k == 1) ? 16'h0000 : 16'(16'h80A0 + k - 1));
    end
    tick(1'b0);
    checkOutput("single_drain_rd",  {12'b0, rd}, 16'h0000);
    checkOutput("single_last_out",  out,         16'h80A6);
    tick(1'b0);
    checkOutput("single_idle_grant", {12'b0, grant}, 16'h0000);
    checkOutput("single_idle_out",   out,            16'h00A6);

    // Round-robin fairness with all four requesters busy
    assertReset(1'b1);
    tick(1'b0);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 8; k++) pushWord(i, 15'(i * 16 + k));
    releaseReset();
    order[0] = 4'b0001;
    order[1] = 4'b0010;
    order[2] = 4'b0100;
    order[3] = 4'b1000;
    order[4] = 4'b0001;
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < MB; b++) begin
        tick(1'b0);
        checkOutput("rr_rd", {12'b0, rd}, {12'b0, order[g]});
      end
    end
    for (int k = 0; k < 14; k++) tick(1'b0);

    // Early drain: owner 2 runs dry after two words, owner 3 follows
    assertReset(1'b1);
    tick(1'b0);
    pushWord(2, 15'h00D1);
    pushWord(2, 15'h00D2);
    for (int k = 1; k <= 3; k++) pushWord(3, 15'(16'h00E0 + k));
    releaseReset();
    tick(1'b0);
    checkOutput("drain_rd1", {12'b0, rd}, 16'h0004);
    tick(1'b0);
    checkOutput("drain_rd2", {12'b0, rd}, 16'h0004);
    tick(1'b0);
    checkOutput("drain_gap_rd",    {12'b0, rd},    16'h0000);
    checkOutput("drain_gap_grant", {12'b0, grant}, 16'h0004);
    tick(1'b0);
    checkOutput("drain_handoff_grant", {12'b0, grant}, 16'h0008);
    checkOutput("drain_gap_out",       out,            16'h00D2);
    for (int k = 0; k < 4; k++) tick(1'b0);

    // Busy stall at cnt=1 for three cycles
    assertReset(1'b1);
    tick(1'b0);
    for (int k = 1; k <= 6; k++) pushWord(1, 15'(16'h00C0 + k));
    releaseReset();
    tick(1'b0);
    checkOutput("busy_first_rd", {12'b0, rd}, 16'h0002);
    for (int k = 0; k < 3; k++) begin
      tick(1'b1);
      checkOutput("busy_stall_rd", {12'b0, rd}, 16'h0000);
      if (k > 0) checkOutput("busy_stall_out", out, 16'h00C1);
    end
    for (int k = 0; k < 3; k++) begin
      tick(1'b0);
      checkOutput("busy_resume_rd", {12'b0, rd}, 16'h0002);
      if (k == 0) checkOutput("busy_stall_out", out, 16'h00C1);
    end
    tick(1'b0);
    checkOutput("busy_regrant_rd", {12'b0, rd}, 16'h0002);
    checkOutput("busy_regrant_out", out, 16'h80C4);
    for (int k = 0; k < 3; k++) tick(1'b0);

    // Asynchronous reset in the middle of a burst
    assertReset(1'b1);
    tick(1'b0);
    for (int k = 1; k <= 4; k++) pushWord(1, 15'(16'h00B0 + k));
    releaseReset();
    tick(1'b0);
    tick(1'b0);
    checkOutput("areset_pre_rd", {12'b0, rd}, 16'h0002);
    #2;
    assertReset(1'b0);
    #1;
    checkOutput("areset_rd",    {12'b0, rd},    16'h0000);
    checkOutput("areset_grant", {12'b0, grant}, 16'h0000);
    checkOutput("areset_out",   out,            16'h0000);
    tick(1'b0);
    releaseReset();
    tick(1'b0);
    checkOutput("areset_restart_grant", {12'b0, grant}, 16'h0002);
    tick(1'b0);
    checkOutput("areset_restart_out", out, 16'h80B2);
    for (int k = 0; k < 4; k++) tick(1'b0);

    // All requests vanish during a grant
    assertReset(1'b1);
    tick(1'b0);
    pushWord(0, 15'h00F1);
    pushWord(0, 15'h00F2);
    releaseReset();
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    checkOutput("idle_empty_rd", {12'b0, rd}, 16'h0000);
    tick(1'b0);
    checkOutput("idle_grant", {12'b0, grant}, 16'h0000);
    checkOutput("idle_out",   out,            16'h00F2);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0);
      checkOutput("idle_quiet_rd", {12'b0, rd}, 16'h0000);
    end
    pushWord(2, 15'h0123);
    tick(1'b0);
    tick(1'b0);
    checkOutput("idle_wake_grant", {12'b0, grant}, 16'h0004);
    checkOutput("idle_wake_rd",    {12'b0, rd},    16'h0004);
    tick(1'b0);
    checkOutput("idle_wake_out", out, 16'h8123);
    tick(1'b0);
    tick(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
